// File: rtl/crc_arb_ctrl.sv
// Round-robin front end that streams framed beats from NUM_REQ requesters into an
// external CRC engine and returns the finished CRC. Define CRC_ARB_TIMEOUT_EN to add a stall watchdog.
module crc_arb_ctrl #(
    parameter int DATA_BYTES = 8,
    parameter int CRC_WIDTH  = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_BYTES*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [CRC_WIDTH-1:0]            cfg_init,
    input  logic [CRC_WIDTH-1:0]            cfg_xor,
    input  logic                            cfg_refl_in,
    input  logic                            cfg_refl_out,
    output logic [DATA_BYTES*8-1:0]         eng_data,
    output logic [CRC_WIDTH-1:0]            eng_crc_in,
    output logic                            eng_enable,
    output logic                            eng_refl_in,
    input  logic [CRC_WIDTH-1:0]            eng_crc_out,
    output logic                            res_valid,
    output logic [CRC_WIDTH-1:0]            res_crc,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic                            res_err,
    input  logic                            res_ready
);

    localparam int DW  = DATA_BYTES * 8;
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    function automatic logic [CRC_WIDTH-1:0] bit_rev(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = v[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [IDW-1:0]       grant_r;
    logic [IDW-1:0]       grant_s;
    logic [IDW-1:0]       rr_ptr_r;
    logic [IDW-1:0]       rr_next_s;
    logic                 any_req_s;
    logic                 accept_s;
    logic                 first_r;
    logic                 fresh_r;
    logic [CRC_WIDTH-1:0] crc_hold_r;
    logic [CRC_WIDTH-1:0] init_r;
    logic [CRC_WIDTH-1:0] xor_r;
    logic                 refl_in_r;
    logic                 refl_out_r;
    logic                 res_valid_r;
    logic [CRC_WIDTH-1:0] res_crc_r;
    logic [IDW-1:0]       res_id_r;
    logic                 tmo_hit_s;

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        logic [IDW:0] idx_v;
        grant_s   = rr_ptr_r;
        any_req_s = 1'b0;
        idx_v     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            idx_v = (idx_v >= (IDW+1)'(NUM_REQ)) ? idx_v - (IDW+1)'(NUM_REQ) : idx_v;
            if (!any_req_s && req_valid[idx_v[IDW-1:0]]) begin
                grant_s   = idx_v[IDW-1:0];
                any_req_s = 1'b1;
            end else begin
                grant_s   = grant_s;
            end
        end
        rr_next_s = (grant_s == IDW'(NUM_REQ - 1)) ? '0 : grant_s + IDW'(1);
    end

    assign accept_s = (state_r == STREAM) && req_valid[grant_r];

    // Beat path to the engine; the held copy covers cycles where the engine output is stale
    always_comb begin
        req_ready = '0;
        eng_data  = '0;
        if (state_r == STREAM) begin
            req_ready[grant_r] = 1'b1;
        end else begin
            req_ready = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r == IDW'(i)) begin
                eng_data = req_data[i*DW +: DW];
            end else begin
                eng_data = eng_data;
            end
        end
        if (first_r) begin
            eng_crc_in = init_r;
        end else if (fresh_r) begin
            eng_crc_in = eng_crc_out;
        end else begin
            eng_crc_in = crc_hold_r;
        end
    end

    assign eng_enable  = accept_s;
    assign eng_refl_in = refl_in_r;
    assign res_valid   = res_valid_r;
    assign res_crc     = res_crc_r;
    assign res_id      = res_id_r;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (accept_s && req_last[grant_r]) begin
                    state_s = DRAIN;
                end else if (tmo_hit_s) begin
                    state_s = RESULT;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: state_s = RESULT;
            RESULT: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESULT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

`ifdef CRC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_r;
    logic          res_err_r;

    assign tmo_hit_s = (state_r == STREAM) && !accept_s && (tmo_cnt_r == TW'(TIMEOUT - 1));
    assign res_err   = res_err_r;

    // Consecutive stall cycles of the granted requester
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r != STREAM || accept_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign res_err   = 1'b0 & (TIMEOUT > 0);
`endif

    // State, grant, frame configuration and result registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            first_r     <= 1'b0;
            fresh_r     <= 1'b0;
            crc_hold_r  <= '0;
            init_r      <= '0;
            xor_r       <= '0;
            refl_in_r   <= 1'b0;
            refl_out_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_crc_r   <= '0;
            res_id_r    <= '0;
`ifdef CRC_ARB_TIMEOUT_EN
            res_err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            fresh_r <= accept_s;
            if (fresh_r) begin
                crc_hold_r <= eng_crc_out;
            end
            if (state_r == IDLE && any_req_s) begin
                grant_r    <= grant_s;
                rr_ptr_r   <= rr_next_s;
                first_r    <= 1'b1;
                init_r     <= cfg_init;
                xor_r      <= cfg_xor;
                refl_in_r  <= cfg_refl_in;
                refl_out_r <= cfg_refl_out;
            end else if (accept_s) begin
                first_r <= 1'b0;
            end
            case (state_r)
                STREAM: begin
                    if (tmo_hit_s) begin
                        res_valid_r <= 1'b1;
                        res_crc_r   <= '0;
                        res_id_r    <= grant_r;
`ifdef CRC_ARB_TIMEOUT_EN
                        res_err_r   <= 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    res_valid_r <= 1'b1;
                    res_crc_r   <= refl_out_r ? bit_rev(eng_crc_out ^ xor_r) : (eng_crc_out ^ xor_r);
                    res_id_r    <= grant_r;
`ifdef CRC_ARB_TIMEOUT_EN
                    res_err_r   <= 1'b0;
`endif
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_arb_ctrl.sv
// Scoreboard bench for crc_arb_ctrl with a behavioural CRC engine whose output
// is only trustworthy in the cycle after an enabled beat.
module tb_crc_arb_ctrl;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [1:0]   req_valid;
    logic [127:0] req_data;
    logic [1:0]   req_last;
    logic [1:0]   req_ready;
    logic [31:0]  cfg_init;
    logic [31:0]  cfg_xor;
    logic         cfg_refl_in;
    logic         cfg_refl_out;
    logic [63:0]  eng_data;
    logic [31:0]  eng_crc_in;
    logic         eng_enable;
    logic         eng_refl_in;
    logic [31:0]  eng_crc_out;
    logic         res_valid;
    logic [31:0]  res_crc;
    logic [0:0]   res_id;
    logic         res_err;
    logic         res_ready;

    logic         drv_valid [2];
    logic         drv_last  [2];
    logic [63:0]  drv_data  [2];
    logic [63:0]  beat_mem  [2][8];

    typedef struct packed {
        logic [31:0] crc;
        logic        id;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int   total = 0;
    int   bad   = 0;
    logic        hold_r = 1'b0;
    logic [31:0] hold_crc = 32'h0;

    crc_arb_ctrl #(.DATA_BYTES(8), .CRC_WIDTH(32), .NUM_REQ(2), .TIMEOUT(64)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .cfg_init(cfg_init), .cfg_xor(cfg_xor), .cfg_refl_in(cfg_refl_in), .cfg_refl_out(cfg_refl_out),
        .eng_data(eng_data), .eng_crc_in(eng_crc_in), .eng_enable(eng_enable), .eng_refl_in(eng_refl_in),
        .eng_crc_out(eng_crc_out),
        .res_valid(res_valid), .res_crc(res_crc), .res_id(res_id), .res_err(res_err), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]          = drv_valid[i];
            req_last[i]           = drv_last[i];
            req_data[i*64 +: 64]  = drv_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // Engine: MSB-first byte-wise CRC, poly 0x04C11DB7, optional input byte reflection
    function automatic logic [31:0] eng_step(input logic [31:0] c_in, input logic [63:0] d, input logic refl);
        logic [31:0] c;
        logic [7:0]  by;
        c = c_in;
        for (int k = 7; k >= 0; k--) begin
            by = d[k*8 +: 8];
            if (refl) by = {by[0], by[1], by[2], by[3], by[4], by[5], by[6], by[7]};
            c = c ^ {by, 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return c;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) eng_crc_out <= 32'h0;
        else if (eng_enable) eng_crc_out <= eng_step(eng_crc_in, eng_data, eng_refl_in);
        else eng_crc_out <= eng_crc_out ^ 32'h5A5A_C3C3;
    end

    // Golden: reflected LSB-first algorithm when reflecting, bit-serial MSB-first otherwise
    function automatic logic [31:0] golden(input int id, input int nb);
        logic [31:0] c;
        logic [7:0]  by;
        logic        fb;
        c = cfg_init;
        for (int b = 0; b < nb; b++) begin
            for (int k = 7; k >= 0; k--) begin
                by = beat_mem[id][b][k*8 +: 8];
                if (cfg_refl_in) begin
                    c = c ^ {24'h0, by};
                    for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
                end else begin
                    for (int j = 7; j >= 0; j--) begin
                        fb = c[31] ^ by[j];
                        c  = {c[30:0], 1'b0};
                        if (fb) c = c ^ 32'h04C1_1DB7;
                    end
                end
            end
        end
        return c ^ cfg_xor;
    endfunction

    task automatic fill(input int id, input int nb);
        for (int b = 0; b < nb; b++) beat_mem[id][b] = {$urandom, $urandom};
    endtask

    task automatic push_exp(input int id, input int nb);
        exp_t e;
        e.crc = golden(id, nb);
        e.id  = id[0];
        e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drive_beat(input int id, input logic [63:0] d, input logic last);
        logic [1:0] others;
        int w;
        drv_data[id]  = d;
        drv_last[id]  = last;
        drv_valid[id] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!req_ready[id] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("beat_ready", req_ready[id], 64'd1);
        if (req_ready[id]) begin
            others     = req_ready;
            others[id] = 1'b0;
            chk("ready_excl", others, 64'd0);
            chk("eng_enable", eng_enable, 64'd1);
            chk("eng_data", eng_data, d);
        end
        @(posedge clk);
        #1;
        drv_valid[id] = 1'b0;
        drv_last[id]  = 1'b0;
    endtask

    task automatic send_frame(input int id, input int nb);
        for (int b = 0; b < nb; b++) drive_beat(id, beat_mem[id][b], (b == nb - 1));
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(negedge clk);
        chk("sb_drain", exp_q.size(), 64'd0);
        @(negedge clk);
    endtask

    task automatic set_crc32();
        cfg_init = 32'hFFFF_FFFF; cfg_xor = 32'hFFFF_FFFF; cfg_refl_in = 1'b1; cfg_refl_out = 1'b1;
    endtask

    // Result monitor: scoreboard pop on handshake, stability while back-pressured
    always @(negedge clk) begin
        if (!n_rst) begin
            hold_r <= 1'b0;
        end else begin
            if (hold_r) begin
                chk("res_hold_valid", res_valid, 64'd1);
                chk("res_hold_crc", res_crc, hold_crc);
            end
            if (res_valid) begin
                chk("no_grant_in_result", req_ready, 64'd0);
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("res_unexpected", res_valid, 64'd0);
                    end else begin
                        chk("res_crc", res_crc, exp_q[0].crc);
                        chk("res_id", res_id, exp_q[0].id);
                        chk("res_err", res_err, exp_q[0].err);
                        void'(exp_q.pop_front());
                    end
                end
            end
            hold_r   <= res_valid && !res_ready;
            hold_crc <= res_crc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            drv_valid[i] = 1'b0; drv_last[i] = 1'b0; drv_data[i] = 64'h0;
        end
        res_ready = 1'b1;
        set_crc32();
        n_rst = 1'b0;
        drv_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 64'd0);
        chk("rst_res_crc", res_crc, 64'd0);
        chk("rst_res_id", res_id, 64'd0);
        chk("rst_res_err", res_err, 64'd0);
        chk("rst_req_ready", req_ready, 64'd0);
        chk("rst_eng_enable", eng_enable, 64'd0);
        drv_valid[0] = 1'b0;
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk);
        #1;

        // both requesters after reset: req0 first
        fill(0, 2); fill(1, 2);
        push_exp(0, 2); push_exp(1, 2);
        fork
            send_frame(0, 2);
            send_frame(1, 2);
        join
        wait_idle();

        // known single-beat CRC-32 frame, result two cycles after acceptance
        beat_mem[0][0] = 64'h3132_3334_3536_3738;
        push_exp(0, 1);
        drive_beat(0, beat_mem[0][0], 1'b1);
        @(negedge clk) chk("lat_drain", res_valid, 64'd0);
        @(negedge clk) chk("lat_result", res_valid, 64'd1);
        wait_idle();

        // req0 was granted last, so req1 goes first now
        fill(0, 1); fill(1, 1);
        push_exp(1, 1); push_exp(0, 1);
        fork
            send_frame(0, 1);
            send_frame(1, 1);
        join
        wait_idle();

        // stalled 4-beat frame with configuration changed mid-frame
        fill(0, 4);
        push_exp(0, 4);
        drive_beat(0, beat_mem[0][0], 1'b0);
        drive_beat(0, beat_mem[0][1], 1'b0);
        cfg_init = 32'h0; cfg_xor = 32'h0; cfg_refl_in = 1'b0; cfg_refl_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive_beat(0, beat_mem[0][2], 1'b0);
        drive_beat(0, beat_mem[0][3], 1'b1);
        set_crc32();
        wait_idle();

        // result back-pressure with a competing requester waiting
        res_ready = 1'b0;
        fill(0, 2); fill(1, 1);
        push_exp(0, 2);
        send_frame(0, 2);
        push_exp(1, 1);
        fork
            send_frame(1, 1);
            begin
                for (int w = 0; w < 20 && !res_valid; w++) @(negedge clk);
                repeat (5) @(negedge clk);
                chk("held_valid", res_valid, 64'd1);
                chk("held_no_grant", req_ready, 64'd0);
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        wait_idle();

        // non-reflected configuration, asymmetric init/xor
        cfg_init = 32'h1234_5678; cfg_xor = 32'hA5A5_0F0F; cfg_refl_in = 1'b0; cfg_refl_out = 1'b0;
        fill(1, 3);
        push_exp(1, 3);
        send_frame(1, 3);
        wait_idle();
        set_crc32();

        // reset in the middle of a frame
        fill(0, 4);
        drive_beat(0, beat_mem[0][0], 1'b0);
        drive_beat(0, beat_mem[0][1], 1'b0);
        drv_data[0] = beat_mem[0][2]; drv_valid[0] = 1'b1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_res_valid", res_valid, 64'd0);
        chk("mid_rst_req_ready", req_ready, 64'd0);
        chk("mid_rst_eng_enable", eng_enable, 64'd0);
        chk("mid_rst_res_crc", res_crc, 64'd0);
        drv_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk);
        #1;
        fill(0, 2); fill(1, 1);
        push_exp(0, 2); push_exp(1, 1);
        fork
            send_frame(0, 2);
            send_frame(1, 1);
        join
        wait_idle();

`ifdef CRC_ARB_TIMEOUT_EN
        begin
            exp_t e;
            e.crc = 32'h0; e.id = 1'b0; e.err = 1'b1;
            exp_q.push_back(e);
        end
        fill(0, 2); fill(1, 1);
        fork
            drive_beat(0, beat_mem[0][0], 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                push_exp(1, 1);
                send_frame(1, 1);
            end
        join
        wait_idle();
`else
        fill(0, 2);
        push_exp(0, 2);
        drive_beat(0, beat_mem[0][0], 1'b0);
        repeat (80) @(posedge clk);
        #1;
        chk("stall_no_result", res_valid, 64'd0);
        drive_beat(0, beat_mem[0][1], 1'b1);
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
